tx_point_test_ctrl: RTL and testbench

//   Parametrised TX-initiated point-test controller for the D2C training path.

---
 rtl/pt_pkg.sv | 33 +++
 rtl/pt_sb_arbiter.sv | 64 ++++++
 rtl/tx_point_test_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_tx_point_test_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pt_pkg.sv
// Shared message codes, mode codes and FSM state encodings for the TX point-test controller.
package pt_pkg;

  typedef enum logic [3:0] {
    MSG_NONE        = 4'd0,
    MSG_START_REQ   = 4'd1,
    MSG_START_RESP  = 4'd2,
    MSG_RESULT_REQ  = 4'd3,
    MSG_RESULT_RESP = 4'd4,
    MSG_END_REQ     = 4'd5,
    MSG_END_RESP    = 4'd6
  } msg_e;

  localparam logic [1:0] MODE_LFSR     = 2'b00;
  localparam logic [1:0] MODE_LANE     = 2'b01;
  localparam logic [1:0] MODE_VALTRAIN = 2'b10;
  localparam logic [1:0] MODE_LFSR_ALT = 2'b11;

  typedef enum logic [3:0] {
    I_IDLE, I_SEND_START, I_WAIT_START, I_PATTERN, I_SEND_RES,
    I_WAIT_RES, I_SEND_END, I_WAIT_END, I_DONE, I_ERR
  } init_state_e;

  typedef enum logic [2:0] {
    R_IDLE, R_SEND_SRESP, R_ACTIVE, R_SEND_RRESP, R_SEND_ERESP, R_DONE
  } resp_state_e;

  // Mode 11 is an alias of the LFSR mode.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == MODE_LFSR_ALT) ? MODE_LFSR : m;
  endfunction

endpackage

// File: rtl/pt_sb_arbiter.sv
// Two-requester sideband arbiter: responder has priority, grant and payload held until accept.
module pt_sb_arbiter
  import pt_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              rsp_req_i,
  input  logic [3:0]        rsp_msg_i,
  input  logic [DATA_W-1:0] rsp_data_i,
  input  logic              rsp_dv_i,
  input  logic              ini_req_i,
  input  logic [3:0]        ini_msg_i,
  input  logic [DATA_W-1:0] ini_data_i,
  input  logic              ini_dv_i,
  input  logic              sb_busy_i,
  output logic              rsp_ack_o,
  output logic              ini_ack_o,
  output logic              sb_valid_o,
  output logic [3:0]        sb_msg_o,
  output logic [DATA_W-1:0] sb_data_o,
  output logic              sb_data_valid_o
);

  logic              vld_q;
  logic              gnt_ini_q;
  logic [3:0]        msg_q;
  logic [DATA_W-1:0] data_q;
  logic              dv_q;
  logic              accept;

  assign accept = vld_q & ~sb_busy_i;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      vld_q     <= 1'b0;
      gnt_ini_q <= 1'b0;
    end else if (accept) begin
      vld_q <= 1'b0;
    end else if (!vld_q && (rsp_req_i || ini_req_i)) begin
      vld_q     <= 1'b1;
      gnt_ini_q <= ~rsp_req_i;
    end
  end

  // Payload is captured while idle; outputs are gated so no reset is needed here.
  always_ff @(posedge clk) begin
    if (!vld_q) begin
      msg_q  <= rsp_req_i ? rsp_msg_i  : ini_msg_i;
      data_q <= rsp_req_i ? rsp_data_i : ini_data_i;
      dv_q   <= rsp_req_i ? rsp_dv_i   : ini_dv_i;
    end
  end

  assign rsp_ack_o       = accept & ~gnt_ini_q;
  assign ini_ack_o       = accept &  gnt_ini_q;
  assign sb_valid_o      = vld_q;
  assign sb_msg_o        = vld_q ? msg_q  : 4'd0;
  assign sb_data_o       = vld_q ? data_q : '0;
  assign sb_data_valid_o = vld_q & dv_q;

endmodule

// File: rtl/tx_point_test_ctrl.sv
// TX-initiated point-test controller: initiator and responder FSMs sharing one sideband.
// Optional response-wait timeout is built when PT_TIMEOUT_EN is defined.
module tx_point_test_ctrl
  import pt_pkg::*;
#(
  parameter int NUM_LANES   = 16,
  parameter int ITER_W      = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic [1:0]           i_mode,
  input  logic [ITER_W-1:0]    i_num_iter,
  input  logic                 i_pattern_finished,
  input  logic [3:0]           i_sb_msg,
  input  logic                 i_sb_msg_valid,
  input  logic [NUM_LANES-1:0] i_sb_data,
  input  logic                 i_sb_busy,
  input  logic [NUM_LANES-1:0] i_cmp_results,
  input  logic                 i_cmp_valid_result,
  output logic [3:0]           o_sb_msg,
  output logic                 o_sb_valid,
  output logic [NUM_LANES-1:0] o_sb_data,
  output logic                 o_sb_data_valid,
  output logic                 o_pattern_en,
  output logic [1:0]           o_pattern_cw,
  output logic                 o_cmp_en,
  output logic [1:0]           o_cmp_cw,
  output logic                 o_test_ack,
  output logic [NUM_LANES-1:0] o_lanes_result,
  output logic                 o_valid_result,
  output logic                 o_timeout
);

  init_state_e          ini_st_q;
  resp_state_e          rsp_st_q;
  logic                 clr;
  logic [1:0]           mode_q;
  logic [ITER_W-1:0]    iter_q;
  logic [NUM_LANES-1:0] lanes_q;
  logic                 vres_q;
  logic                 ack_q;
  logic                 tmo_q;
  logic [1:0]           cmp_cw_q;
  logic                 cmp_en_q;
  logic [NUM_LANES-1:0] rdata_q;
  logic                 rsp_ack, ini_ack;
  logic                 tmo_hit;
  logic [ITER_W:0]      iter_next, iter_tgt;

  assign clr       = rst | ~i_en;
  assign iter_next = {1'b0, iter_q} + 1'b1;
  assign iter_tgt  = (i_num_iter == '0) ? (ITER_W+1)'(1) : {1'b0, i_num_iter};

  function automatic logic rx(input logic [3:0] code);
    return i_sb_msg_valid && (i_sb_msg == code);
  endfunction

`ifdef PT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wcnt_q;
  logic          in_wait;

  assign in_wait = ini_st_q inside {I_WAIT_START, I_WAIT_RES, I_WAIT_END};
  assign tmo_hit = in_wait && (wcnt_q == TW'(TIMEOUT_CYC - 1));

  // Every exit from a wait state goes to a non-wait state, so clearing outside waits restarts it per state.
  always_ff @(posedge clk) begin
    if (clr || !in_wait) wcnt_q <= '0;
    else                 wcnt_q <= wcnt_q + 1'b1;
  end
`else
  logic tmo_unused;
  assign tmo_unused = (TIMEOUT_CYC == 0);
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      ini_st_q <= I_IDLE;
      mode_q   <= 2'b00;
      iter_q   <= '0;
      lanes_q  <= '1;
      vres_q   <= 1'b1;
      tmo_q    <= 1'b0;
    end else begin
      case (ini_st_q)
        I_IDLE: begin
          ini_st_q <= I_SEND_START;
          mode_q   <= norm_mode(i_mode);
        end
        I_SEND_START: if (ini_ack) ini_st_q <= I_WAIT_START;
        I_WAIT_START: begin
          if (rx(MSG_START_RESP)) ini_st_q <= I_PATTERN;
          else if (tmo_hit) begin
            ini_st_q <= I_ERR; tmo_q <= 1'b1; lanes_q <= '0; vres_q <= 1'b0;
          end
        end
        I_PATTERN:  if (i_pattern_finished) ini_st_q <= I_SEND_RES;
        I_SEND_RES: if (ini_ack) ini_st_q <= I_WAIT_RES;
        I_WAIT_RES: begin
          if (rx(MSG_RESULT_RESP)) begin
            lanes_q  <= lanes_q & i_sb_data;
            vres_q   <= vres_q & i_sb_data[0];
            iter_q   <= iter_next[ITER_W-1:0];
            ini_st_q <= (iter_next < iter_tgt) ? I_SEND_START : I_SEND_END;
          end else if (tmo_hit) begin
            ini_st_q <= I_ERR; tmo_q <= 1'b1; lanes_q <= '0; vres_q <= 1'b0;
          end
        end
        I_SEND_END: if (ini_ack) ini_st_q <= I_WAIT_END;
        I_WAIT_END: begin
          if (rx(MSG_END_RESP)) ini_st_q <= I_DONE;
          else if (tmo_hit) begin
            ini_st_q <= I_ERR; tmo_q <= 1'b1; lanes_q <= '0; vres_q <= 1'b0;
          end
        end
        I_DONE, I_ERR: ini_st_q <= ini_st_q;
        default: ini_st_q <= I_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rsp_st_q <= R_IDLE;
      cmp_en_q <= 1'b0;
      cmp_cw_q <= 2'b00;
    end else begin
      case (rsp_st_q)
        R_IDLE, R_ACTIVE: begin
          if (rx(MSG_START_REQ)) begin
            cmp_cw_q <= i_sb_data[1:0];
            cmp_en_q <= 1'b1;
            rsp_st_q <= R_SEND_SRESP;
          end else if (rsp_st_q == R_ACTIVE && rx(MSG_RESULT_REQ)) begin
            rsp_st_q <= R_SEND_RRESP;
          end else if (rsp_st_q == R_ACTIVE && rx(MSG_END_REQ)) begin
            cmp_en_q <= 1'b0;
            rsp_st_q <= R_SEND_ERESP;
          end
        end
        R_SEND_SRESP: if (rsp_ack) rsp_st_q <= R_ACTIVE;
        R_SEND_RRESP: if (rsp_ack) rsp_st_q <= R_ACTIVE;
        R_SEND_ERESP: if (rsp_ack) rsp_st_q <= R_DONE;
        R_DONE:       rsp_st_q <= R_DONE;
        default:      rsp_st_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_st_q == R_ACTIVE && rx(MSG_RESULT_REQ))
      rdata_q <= (cmp_cw_q == MODE_VALTRAIN) ? NUM_LANES'(i_cmp_valid_result) : i_cmp_results;
  end

  always_ff @(posedge clk) begin
    if (clr) ack_q <= 1'b0;
    else     ack_q <= ((ini_st_q == I_DONE) && (rsp_st_q == R_DONE)) || (ini_st_q == I_ERR) || tmo_hit;
  end

  logic                 ini_req, rsp_req;
  logic [3:0]           ini_msg, rsp_msg;
  logic [NUM_LANES-1:0] ini_data, rsp_data;

  assign ini_req  = ini_st_q inside {I_SEND_START, I_SEND_RES, I_SEND_END};
  assign ini_msg  = (ini_st_q == I_SEND_START) ? MSG_START_REQ :
                    (ini_st_q == I_SEND_RES)   ? MSG_RESULT_REQ : MSG_END_REQ;
  assign ini_data = (ini_st_q == I_SEND_START) ? NUM_LANES'(mode_q) : '0;
  assign rsp_req  = rsp_st_q inside {R_SEND_SRESP, R_SEND_RRESP, R_SEND_ERESP};
  assign rsp_msg  = (rsp_st_q == R_SEND_SRESP) ? MSG_START_RESP :
                    (rsp_st_q == R_SEND_RRESP) ? MSG_RESULT_RESP : MSG_END_RESP;
  assign rsp_data = (rsp_st_q == R_SEND_RRESP) ? rdata_q : '0;

  pt_sb_arbiter #(.DATA_W(NUM_LANES)) u_arb (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (~i_en),
    .rsp_req_i       (rsp_req),
    .rsp_msg_i       (rsp_msg),
    .rsp_data_i      (rsp_data),
    .rsp_dv_i        (rsp_st_q == R_SEND_RRESP),
    .ini_req_i       (ini_req),
    .ini_msg_i       (ini_msg),
    .ini_data_i      (ini_data),
    .ini_dv_i        (1'b0),
    .sb_busy_i       (i_sb_busy),
    .rsp_ack_o       (rsp_ack),
    .ini_ack_o       (ini_ack),
    .sb_valid_o      (o_sb_valid),
    .sb_msg_o        (o_sb_msg),
    .sb_data_o       (o_sb_data),
    .sb_data_valid_o (o_sb_data_valid)
  );

  assign o_pattern_en   = (ini_st_q == I_PATTERN);
  assign o_pattern_cw   = mode_q;
  assign o_cmp_en       = cmp_en_q;
  assign o_cmp_cw       = cmp_cw_q;
  assign o_test_ack     = ack_q;
  assign o_lanes_result = lanes_q;
  assign o_valid_result = vres_q;
  assign o_timeout      = tmo_q;

endmodule

// File: tb/tb_tx_point_test_ctrl.sv
// Directed bench: table of full point-test transactions plus hand-written corner sequences.
module tb_tx_point_test_ctrl;
  import pt_pkg::*;

  logic        clk = 1'b0;
  logic        rst, i_en, i_pattern_finished, i_sb_msg_valid, i_sb_busy, i_cmp_valid_result;
  logic [1:0]  i_mode;
  logic [3:0]  i_num_iter, i_sb_msg;
  logic [15:0] i_sb_data, i_cmp_results;
  logic [3:0]  o_sb_msg;
  logic        o_sb_valid, o_sb_data_valid, o_pattern_en, o_cmp_en, o_test_ack, o_valid_result, o_timeout;
  logic [15:0] o_sb_data, o_lanes_result;
  logic [1:0]  o_pattern_cw, o_cmp_cw;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tx_point_test_ctrl #(.NUM_LANES(16), .ITER_W(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_mode(i_mode), .i_num_iter(i_num_iter),
    .i_pattern_finished(i_pattern_finished), .i_sb_msg(i_sb_msg), .i_sb_msg_valid(i_sb_msg_valid),
    .i_sb_data(i_sb_data), .i_sb_busy(i_sb_busy), .i_cmp_results(i_cmp_results),
    .i_cmp_valid_result(i_cmp_valid_result), .o_sb_msg(o_sb_msg), .o_sb_valid(o_sb_valid),
    .o_sb_data(o_sb_data), .o_sb_data_valid(o_sb_data_valid), .o_pattern_en(o_pattern_en),
    .o_pattern_cw(o_pattern_cw), .o_cmp_en(o_cmp_en), .o_cmp_cw(o_cmp_cw), .o_test_ack(o_test_ack),
    .o_lanes_result(o_lanes_result), .o_valid_result(o_valid_result), .o_timeout(o_timeout)
  );

  typedef struct {
    logic [3:0]  iter;
    logic [1:0]  mode;
    logic [1:0]  exp_cw;
    logic [15:0] d0, d1, d2;
    logic [15:0] cmp;
    logic        cmpv;
    logic [15:0] exp_rdata;
    logic [15:0] exp_lanes;
    logic        exp_vres;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] code, input logic [15:0] data);
    i_sb_msg = code; i_sb_data = data; i_sb_msg_valid = 1'b1;
    @(negedge clk);
    i_sb_msg = 4'd0; i_sb_data = 16'd0; i_sb_msg_valid = 1'b0;
  endtask

  // Waits for a send request, checks its code, then steps past the accepting edge.
  task automatic expect_msg(input logic [3:0] code, input string nm,
                            output logic [15:0] data, output logic dv);
    int n = 0;
    do begin @(negedge clk); n++; end while (!o_sb_valid && n < 40);
    check({nm, "_valid"}, o_sb_valid, 1);
    check({nm, "_code"}, o_sb_msg, code);
    data = o_sb_data;
    dv   = o_sb_data_valid;
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_sb_valid"}, o_sb_valid, 0);
    check({nm, "_sb_msg"}, o_sb_msg, 0);
    check({nm, "_pat_en"}, o_pattern_en, 0);
    check({nm, "_pat_cw"}, o_pattern_cw, 0);
    check({nm, "_cmp_en"}, o_cmp_en, 0);
    check({nm, "_ack"}, o_test_ack, 0);
    check({nm, "_lanes"}, o_lanes_result, 16'hFFFF);
    check({nm, "_vres"}, o_valid_result, 1);
    check({nm, "_tmo"}, o_timeout, 0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [15:0] d;
    logic        dv;
    int          n_it, n;
    n_it = (v.iter == 0) ? 1 : int'(v.iter);
    i_mode = v.mode; i_num_iter = v.iter;
    i_en = 1'b1;
    for (int k = 0; k < n_it; k++) begin
      expect_msg(MSG_START_REQ, "start_req", d, dv);
      check("start_req_mode", d[1:0], v.exp_cw);
      check("start_req_dv", dv, 0);
      check("pattern_cw", o_pattern_cw, v.exp_cw);
      pulse(MSG_START_RESP, 16'd0);
      check("pattern_en_on", o_pattern_en, 1);
      i_pattern_finished = 1'b1;
      @(negedge clk);
      i_pattern_finished = 1'b0;
      check("pattern_en_off", o_pattern_en, 0);
      expect_msg(MSG_RESULT_REQ, "result_req", d, dv);
      pulse(MSG_RESULT_RESP, (k == 0) ? v.d0 : (k == 1) ? v.d1 : v.d2);
    end
    expect_msg(MSG_END_REQ, "end_req", d, dv);
    pulse(MSG_END_RESP, 16'd0);
    i_cmp_results = v.cmp; i_cmp_valid_result = v.cmpv;
    pulse(MSG_START_REQ, {14'd0, v.mode});
    check("cmp_en_on", o_cmp_en, 1);
    check("cmp_cw", o_cmp_cw, v.mode);
    expect_msg(MSG_START_RESP, "start_resp", d, dv);
    pulse(MSG_RESULT_REQ, 16'd0);
    expect_msg(MSG_RESULT_RESP, "result_resp", d, dv);
    check("result_resp_data", d, v.exp_rdata);
    check("result_resp_dv", dv, 1);
    pulse(MSG_END_REQ, 16'd0);
    check("cmp_en_off", o_cmp_en, 0);
    expect_msg(MSG_END_RESP, "end_resp", d, dv);
    n = 0;
    while (!o_test_ack && n < 10) begin @(negedge clk); n++; end
    check("test_ack", o_test_ack, 1);
    check("lanes_result", o_lanes_result, v.exp_lanes);
    check("valid_result", o_valid_result, v.exp_vres);
    i_en = 1'b0;
    @(negedge clk);
    check("ack_drop", o_test_ack, 0);
    check("lanes_restore", o_lanes_result, 16'hFFFF);
  endtask

  initial begin
    logic [15:0] d;
    logic        dv;
    int          n;
    vecs[0] = '{4'd1, 2'b01, 2'b01, 16'hFFFF, 16'h0000, 16'h0000, 16'hA5A5, 1'b0, 16'hA5A5, 16'hFFFF, 1'b1};
    vecs[1] = '{4'd3, 2'b01, 2'b01, 16'hFFF0, 16'hFF0F, 16'hFFFF, 16'h1234, 1'b1, 16'h1234, 16'hFF00, 1'b0};
    vecs[2] = '{4'd0, 2'b11, 2'b00, 16'h7FFE, 16'h0000, 16'h0000, 16'h0F0F, 1'b1, 16'h0F0F, 16'h7FFE, 1'b0};
    vecs[3] = '{4'd2, 2'b10, 2'b10, 16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1, 16'h0001, 16'h0001, 1'b1};

    rst = 1'b1; i_en = 1'b0; i_mode = 2'b01; i_num_iter = 4'd1; i_pattern_finished = 1'b0;
    i_sb_msg = 4'd0; i_sb_msg_valid = 1'b0; i_sb_data = 16'd0; i_sb_busy = 1'b0;
    i_cmp_results = 16'd0; i_cmp_valid_result = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Partner START_REQ arrives while the local START_REQ is being raised.
    i_mode = 2'b01; i_num_iter = 4'd1;
    i_en = 1'b1;
    pulse(MSG_START_REQ, 16'h0001);
    expect_msg(MSG_START_RESP, "arb_first", d, dv);
    expect_msg(MSG_START_REQ, "arb_second", d, dv);
    check("arb_start_mode", d[1:0], 2'b01);
    i_en = 1'b0;
    @(negedge clk);

    // Sideband busy held for five cycles while RESULT_REQ is offered.
    i_en = 1'b1;
    expect_msg(MSG_START_REQ, "busy_start", d, dv);
    pulse(MSG_START_RESP, 16'd0);
    i_pattern_finished = 1'b1;
    @(negedge clk);
    i_pattern_finished = 1'b0;
    i_sb_busy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("busy_valid_hold", o_sb_valid, 1);
      check("busy_msg_hold", o_sb_msg, 4'd3);
    end
    i_sb_busy = 1'b0;
    @(negedge clk);
    check("busy_valid_fall", o_sb_valid, 0);
    pulse(MSG_RESULT_RESP, 16'hFFFF);
    expect_msg(MSG_END_REQ, "busy_end", d, dv);
    i_en = 1'b0;
    @(negedge clk);

    // Enable dropped during PATTERN, then raised again.
    i_en = 1'b1;
    expect_msg(MSG_START_REQ, "abort_start", d, dv);
    pulse(MSG_START_RESP, 16'd0);
    pulse(MSG_START_REQ, 16'h0001);
    check("abort_pat_en", o_pattern_en, 1);
    check("abort_cmp_en", o_cmp_en, 1);
    i_en = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    i_en = 1'b1;
    expect_msg(MSG_START_REQ, "restart", d, dv);
    i_en = 1'b0;
    @(negedge clk);

`ifdef PT_TIMEOUT_EN
    // No START_RESP: timeout after 16 cycles of WAIT_START.
    i_en = 1'b1;
    expect_msg(MSG_START_REQ, "tmo_start", d, dv);
    n = 0;
    while (!o_timeout && n < 40) begin @(negedge clk); n++; end
    check("tmo_flag", o_timeout, 1);
    check("tmo_cycles", n, 16);
    check("tmo_ack", o_test_ack, 1);
    check("tmo_lanes", o_lanes_result, 16'h0000);
    check("tmo_vres", o_valid_result, 0);
    i_en = 1'b0;
    @(negedge clk);
    check("tmo_clear", o_timeout, 0);
`else
    n = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
